response_arbiter: RTL

RESPONSE_ARBITER -- requirements
Module: response_arbiter

---
 rtl/response_arbiter_pkg.sv | 24 ++
 rtl/response_arbiter_rr_select.sv | 40 ++++
 rtl/response_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/response_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : response_arbiter_pkg
// Description : Shared types and constants for the response arbiter and the
//               downstream frame transmitter (FSM state encoding, framing
//               bytes, default frame length).
// Revision    : 1.0 - initial release
// ============================================================================
package response_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD       = 2'd1,
    WAIT_START = 2'd2,
    SEND       = 2'd3
  } state_t;

  localparam logic [7:0] PREAMBLE            = 8'h4D;
  localparam logic [7:0] CR                  = 8'h0D;
  localparam logic [7:0] LF                  = 8'h0A;
  localparam int         FRAME_BYTES_DEFAULT = 7;

endpackage : response_arbiter_pkg
`default_nettype wire

// File: rtl/response_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_select
// Description : Combinational round-robin winner selection. The search
//               starts at index ptr+1 (mod N_REQ) and wraps around, so the
//               requester at ptr has the lowest priority.
// Ports       : req     - request vector, one bit per requester
//               ptr     - index of the previously served requester
//               winner  - index of the selected requester (0 when none)
//               any_req - at least one request bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_select #(
  parameter int N_REQ = 4,
  parameter int GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    ptr,
  output logic [GW-1:0]    winner,
  output logic             any_req
);

  logic [GW-1:0] cand;

  // Scan from the farthest candidate down to the nearest so that the
  // candidate closest to ptr+1 is the last one written and therefore wins.
  always_comb begin
    winner  = '0;
    cand    = '0;
    any_req = |req;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = GW'((int'(ptr) + i) % N_REQ);
      if (req[cand]) begin
        winner = cand;
      end
    end
  end

endmodule : rr_select
`default_nettype wire

// File: rtl/response_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : response_arbiter
// Description : Round-robin arbiter that accepts 16-bit read responses from
//               N_REQ requesters and hands them one at a time to a frame
//               transmitter, waiting for the whole FRAME_BYTES-byte frame to
//               be consumed before accepting the next response.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               req_valid_i   - per-requester response-valid flags
//               req_data_i    - packed responses, 16 bits per requester
//               req_ready_o   - one-cycle accept pulse for the winner
//               rdata_o       - latched response for the transmitter
//               rw_o          - always 0 (read response)
//               valid_o       - one-cycle start strobe to the transmitter
//               tx_valid_i    - transmitter byte-valid
//               tx_ready_i    - byte-sink ready
//               grant_o       - index of the requester being served
//               busy_o        - high whenever the FSM is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module response_arbiter
  import response_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int FRAME_BYTES = FRAME_BYTES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [16*N_REQ-1:0]        req_data_i,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic [15:0]                rdata_o,
  output logic                       rw_o,
  output logic                       valid_o,
  input  logic                       tx_valid_i,
  input  logic                       tx_ready_i,
  output logic [$clog2(N_REQ)-1:0]   grant_o,
  output logic                       busy_o
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(FRAME_BYTES + 1);

  state_t         state;
  state_t         state_nxt;
  logic [GW-1:0]  ptr;
  logic [GW-1:0]  winner;
  logic           any_req;
  logic [CW-1:0]  byte_cnt;
  logic           byte_fire;
  logic           last_byte;

  rr_select #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_rr_select (
    .req     (req_valid_i),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // A byte is only consumed while a frame is in flight and both sides agree.
  assign byte_fire = tx_valid_i && tx_ready_i &&
                     ((state == WAIT_START) || (state == SEND));
  assign last_byte = (byte_cnt == CW'(FRAME_BYTES - 1));

  assign valid_o = (state == LOAD);
  assign busy_o  = (state != IDLE);
  assign rw_o    = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = WAIT_START;
      end
      WAIT_START: begin
        // The first byte may already be consumed on the exit cycle; with a
        // one-byte frame that byte also completes the frame.
        if (tx_valid_i) begin
          state_nxt = (byte_fire && last_byte) ? IDLE : SEND;
        end
      end
      SEND: begin
        if (byte_fire && last_byte) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_o <= '0;
      rdata_o     <= '0;
      grant_o     <= '0;
      byte_cnt    <= '0;
      ptr         <= GW'(N_REQ - 1);
    end else begin
      req_ready_o <= '0;
      if ((state == IDLE) && any_req) begin
        rdata_o     <= req_data_i[16*winner +: 16];
        grant_o     <= winner;
        req_ready_o <= N_REQ'(1) << winner;
      end
      if (state == LOAD) begin
        byte_cnt <= '0;
      end else if (byte_fire) begin
        if (last_byte) begin
          byte_cnt <= '0;
          ptr      <= grant_o;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

endmodule : response_arbiter
`default_nettype wire
